serial_adder: RTL

Multi-cycle, bit-serial adder that sequences two WIDTH-bit operands LSB-first through a single 1-bit full-adder cell, one bit per clock. It registers the carry between bit slices and assembles the sum in a shift register. It feeds the 1-bit cell and consumes its sum and carry outputs. It sits between a start/done requester (control FSM or testbench) and the datapath, trading latency for area against a ripple-carry array.

---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the bit slice of the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: walks the operands LSB-first through one full-adder cell,
// one bit per clock, and publishes {Cout,S} and overflow on a one-cycle done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = fa_s;
        carry_d  = fa_co;
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this final slice
          s_d     = sum_sh_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
